scan_txn_initiator: RTL



---
 rtl/scan_txn_pkg.sv | 41 ++++
 rtl/scan_frame_sr.sv | 32 +++
 rtl/scan_txn_initiator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/scan_txn_pkg.sv
// Shared definitions for the scan-driven static bus initiator: frame layout,
// op encodings, response bit positions and FSM state type.
package scan_txn_pkg;

   localparam int unsigned FRAME_W  = 54;
   localparam int unsigned ADDR_F_W = 20;
   localparam int unsigned DATA_F_W = 32;

   // Command frame field offsets
   localparam int unsigned OP_LSB   = 0;
   localparam int unsigned ADDR_LSB = 2;
   localparam int unsigned DATA_LSB = 22;

   // Response frame bit positions (addr/data reuse the command offsets)
   localparam int unsigned RSP_DONE = 0;
   localparam int unsigned RSP_TO   = 1;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      WAIT
   } state_e;

   // Assemble the response frame loaded back into the shift register
   function automatic logic [FRAME_W-1:0] build_rsp(input logic                timeout,
                                                    input logic [ADDR_F_W-1:0] addr,
                                                    input logic [DATA_F_W-1:0] data);
      logic [FRAME_W-1:0] f;
      f                        = '0;
      f[RSP_DONE]              = 1'b1;
      f[RSP_TO]                = timeout;
      f[ADDR_LSB +: ADDR_F_W]  = addr;
      f[DATA_LSB +: DATA_F_W]  = data;
      return f;
   endfunction

endpackage

// File: rtl/scan_frame_sr.sv
// Frame shift register: serial in at the MSB end, serial out of bit 0,
// parallel load for the response frame. Load takes priority over shift.
module scan_frame_sr
   import scan_txn_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               shift_en,
   input  logic               load_en,
   input  logic [FRAME_W-1:0] load_data,
   input  logic               scan_in,
   output logic               scan_out,
   output logic [FRAME_W-1:0] q
);

   logic [FRAME_W-1:0] r_fr;

   // Parallel load wins over shifting; otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fr <= '0;
      end else if (load_en) begin
         r_fr <= load_data;
      end else if (shift_en) begin
         r_fr <= {scan_in, r_fr[FRAME_W-1:1]};
      end
   end

   assign scan_out = r_fr[0];
   assign q        = r_fr;

endmodule

// File: rtl/scan_txn_initiator.sv
// Initiator end of the group-mux static bus. A serially loaded command frame is
// launched by scan_update; the transaction is announced by toggling scan_id and
// completes on a rising edge of static_ready or on timeout. The response frame
// is then parallel-loaded into the same shift register for shift-out.
// The frame layout assumes the default ADDR_W/DATA_W; TIMEOUT must be >= 1.
module scan_txn_initiator
   import scan_txn_pkg::*;
#(
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scan_en,
   input  logic              scan_in,
   input  logic              scan_update,
   output logic              scan_out,
   output logic              busy,
   output logic              err,
   output logic              static_wen,
   output logic              static_ren,
   output logic [ADDR_W-1:0] static_addr,
   output logic [DATA_W-1:0] static_wdata,
   input  logic [DATA_W-1:0] static_rdata,
   input  logic              static_ready,
   output logic              scan_id
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   // Counter value seen in the last permitted WAIT cycle
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e              r_state;
   logic                r_ready_q;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_busy;
   logic                r_err;
   logic                r_wen;
   logic                r_ren;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_scan_id;

   logic [FRAME_W-1:0]  w_frame;
   logic [FRAME_W-1:0]  w_load_data;
   logic [DATA_W-1:0]   w_rsp_data;
   logic [1:0]          w_op;
   logic                w_op_valid;
   logic                w_rise;
   logic                w_launch;
   logic                w_done_ok;
   logic                w_done_to;
   logic                w_shift;
   logic                w_load;

   scan_frame_sr u_frame (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en  (w_shift),
      .load_en   (w_load),
      .load_data (w_load_data),
      .scan_in   (scan_in),
      .scan_out  (scan_out),
      .q         (w_frame)
   );

   // Decode the held frame, detect the ready edge and form control strobes
   always_comb begin
      w_op = w_frame[OP_LSB +: 2];
      unique case (w_op)
         OP_NOP:       w_op_valid = 1'b0;
         OP_WR, OP_RD: w_op_valid = 1'b1;
         default:      w_op_valid = 1'b0;
      endcase
      // Only a fresh edge completes, so a level left high from before is ignored
      w_rise    = static_ready & ~r_ready_q;
      // scan_en wins over scan_update in the same cycle
      w_launch  = (r_state == IDLE) && scan_update && !scan_en && w_op_valid;
      w_shift   = (r_state == IDLE) && scan_en;
      w_done_ok = (r_state == WAIT) && w_rise;
      w_done_to = (r_state == WAIT) && !w_rise && (r_cnt == CNT_LAST);
      w_load    = w_done_ok | w_done_to;
      // Reads return the data sampled on the ready-edge cycle; writes echo wdata
      w_rsp_data  = r_wen ? r_wdata : static_rdata;
      w_load_data = build_rsp(w_done_to, r_addr, w_rsp_data);
   end

   // Transaction FSM with all bus-facing outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ready_q <= 1'b0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_wen     <= 1'b0;
         r_ren     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_scan_id <= 1'b0;
      end else begin
         r_ready_q <= static_ready;
         unique case (r_state)
            IDLE: begin
               if (w_launch) begin
                  r_addr  <= w_frame[ADDR_LSB +: ADDR_W];
                  r_wdata <= w_frame[DATA_LSB +: DATA_W];
                  r_wen   <= (w_op == OP_WR);
                  r_ren   <= (w_op == OP_RD);
                  r_busy  <= 1'b1;
                  r_err   <= 1'b0;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               r_scan_id <= ~r_scan_id;
               r_cnt     <= '0;
               r_state   <= WAIT;
            end
            WAIT: begin
               if (w_done_ok) begin
                  r_wen   <= 1'b0;
                  r_ren   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_done_to) begin
                  r_wen   <= 1'b0;
                  r_ren   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy         = r_busy;
   assign err          = r_err;
   assign static_wen   = r_wen;
   assign static_ren   = r_ren;
   assign static_addr  = r_addr;
   assign static_wdata = r_wdata;
   assign scan_id      = r_scan_id;

endmodule
